// File: rtl/bp_cce_mem_cmd_credit_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : bp_cce_mem_cmd_credit_buffer
//  Purpose  : Outbound buffer between the CCE message unit's memory-command
//             port and the memory network. Commands enter an els_p-deep FIFO
//             through a ready&valid handshake and leave through a valid->yumi
//             handshake. A credit counter bounds the number of outstanding
//             memory commands; each consumed mem_resp returns one credit.
//
//  Ports    : clk_i, reset_n_i           clock, async active-low reset
//             mem_cmd_i/_v_i/_ready_o    enqueue side (message unit)
//             mem_cmd_o/_v_o/_yumi_i     dequeue side (memory network)
//             mem_resp_yumi_i            credit return
//             credit_count_o             credits currently available
//             credits_empty_o/_full_o    count == 0 / count == credits_p
//             credit_err_o               sticky: credit returned while full
//
//  Revision : 1.0  initial release
// ============================================================================
module bp_cce_mem_cmd_credit_buffer #(
    parameter  int msg_width_p = 64,
    parameter  int els_p       = 2,
    parameter  int credits_p   = 8,
    localparam int ptr_w       = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_w       = $clog2(credits_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,

    input  logic [msg_width_p-1:0] mem_cmd_i,
    input  logic                   mem_cmd_v_i,
    output logic                   mem_cmd_ready_o,

    output logic [msg_width_p-1:0] mem_cmd_o,
    output logic                   mem_cmd_v_o,
    input  logic                   mem_cmd_yumi_i,

    input  logic                   mem_resp_yumi_i,

    output logic [cnt_w-1:0]       credit_count_o,
    output logic                   credits_empty_o,
    output logic                   credits_full_o,
    output logic                   credit_err_o
);

    localparam int                 c_occ_w       = $clog2(els_p + 1);
    localparam logic [ptr_w-1:0]   c_last_ptr    = ptr_w'(els_p - 1);
    localparam logic [c_occ_w-1:0] c_occ_full    = c_occ_w'(els_p);
    localparam logic [cnt_w-1:0]   c_credits_max = cnt_w'(credits_p);

    logic [msg_width_p-1:0] r_mem [els_p];
    logic [ptr_w-1:0]       r_wptr;
    logic [ptr_w-1:0]       r_rptr;
    logic [c_occ_w-1:0]     r_occ;
    logic [cnt_w-1:0]       r_credits;
    logic                   r_err;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_enq;
    logic                   w_deq;
    logic                   w_ret;

    assign w_full  = (r_occ == c_occ_full);
    assign w_empty = (r_occ == '0);

    // Ready depends only on registered occupancy, so a dequeue in the same
    // cycle never opens a slot combinationally.
    assign mem_cmd_ready_o = ~w_full;
    assign mem_cmd_v_o     = ~w_empty & (r_credits != '0);
    assign mem_cmd_o       = r_mem[r_rptr];

    assign w_enq = mem_cmd_v_i & mem_cmd_ready_o;
    // A yumi without valid is a protocol violation; masking it here keeps
    // pointers and credits untouched in that case.
    assign w_deq = mem_cmd_yumi_i & mem_cmd_v_o;
    assign w_ret = mem_resp_yumi_i;

    assign credit_count_o  = r_credits;
    assign credits_empty_o = (r_credits == '0);
    assign credits_full_o  = (r_credits == c_credits_max);
    assign credit_err_o    = r_err;

    // Storage carries no reset: contents are only observed behind valid.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= mem_cmd_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + ptr_w'(1);
            end
            if (w_deq) begin
                r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + ptr_w'(1);
            end
            if (w_enq && !w_deq) begin
                r_occ <= r_occ + c_occ_w'(1);
            end else if (w_deq && !w_enq) begin
                r_occ <= r_occ - c_occ_w'(1);
            end
        end
    end

    // Underflow is impossible since dequeue requires a nonzero count.
    // A return with nothing outstanding saturates and latches the error.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_credits <= c_credits_max;
            r_err     <= 1'b0;
        end else begin
            if (w_deq && !w_ret) begin
                r_credits <= r_credits - cnt_w'(1);
            end else if (w_ret && !w_deq) begin
                if (r_credits == c_credits_max) begin
                    r_err <= 1'b1;
                end else begin
                    r_credits <= r_credits + cnt_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_cce_mem_cmd_credit_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_cce_mem_cmd_credit_buffer
//  Purpose  : Self-checking bench for bp_cce_mem_cmd_credit_buffer. A queue
//             plus integer credit count models the buffer; directed and
//             randomized scenarios compare the DUT against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_cce_mem_cmd_credit_buffer;

    localparam int W    = 64;
    localparam int ELS  = 2;
    localparam int CRED = 8;
    localparam int CW   = $clog2(CRED + 1);

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [W-1:0]  mem_cmd_i;
    logic          mem_cmd_v_i;
    logic          mem_cmd_ready_o;
    logic [W-1:0]  mem_cmd_o;
    logic          mem_cmd_v_o;
    logic          mem_cmd_yumi_i;
    logic          mem_resp_yumi_i;
    logic [CW-1:0] credit_count_o;
    logic          credits_empty_o;
    logic          credits_full_o;
    logic          credit_err_o;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [W-1:0] q[$];
    int           m_credits;
    bit           m_err;

    always #5 clk_i = ~clk_i;

    bp_cce_mem_cmd_credit_buffer #(
        .msg_width_p (W),
        .els_p       (ELS),
        .credits_p   (CRED)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .mem_cmd_i       (mem_cmd_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_ready_o (mem_cmd_ready_o),
        .mem_cmd_o       (mem_cmd_o),
        .mem_cmd_v_o     (mem_cmd_v_o),
        .mem_cmd_yumi_i  (mem_cmd_yumi_i),
        .mem_resp_yumi_i (mem_resp_yumi_i),
        .credit_count_o  (credit_count_o),
        .credits_empty_o (credits_empty_o),
        .credits_full_o  (credits_full_o),
        .credit_err_o    (credit_err_o)
    );

    function automatic void model_reset();
        q.delete();
        m_credits = CRED;
        m_err     = 1'b0;
    endfunction

    function automatic logic exp_v();
        return (q.size() > 0) && (m_credits > 0);
    endfunction

    // Called at a falling edge: drive one cycle of inputs, advance the model
    // by the rules of the buffer, return at the next falling edge.
    task automatic step(input logic v, input logic [W-1:0] d,
                        input logic y, input logic r);
        logic enq, deq;
        mem_cmd_v_i     = v;
        mem_cmd_i       = d;
        mem_cmd_yumi_i  = y;
        mem_resp_yumi_i = r;
        enq = v && (q.size() < ELS);
        deq = y && exp_v();
        @(posedge clk_i);
        if (deq) void'(q.pop_front());
        if (enq) q.push_back(d);
        if (deq && !r) m_credits--;
        else if (r && !deq) begin
            if (m_credits == CRED) m_err = 1'b1;
            else m_credits++;
        end
        @(negedge clk_i);
    endtask

    task automatic restore_credits();
        while (m_credits < CRED) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        mem_cmd_v_i = 1'b0; mem_cmd_i = '0; mem_cmd_yumi_i = 1'b0; mem_resp_yumi_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        step(1'b1, 64'hAB, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 64'hCD, 1'b0, 1'b0);
        // Assert reset between edges; outputs must respond without a clock.
        #2 reset_n_i = 1'b0;
        #1;
        checks++; if (mem_cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", mem_cmd_ready_o); end
        checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %b want 0", mem_cmd_v_o); end
        checks++; if (credit_count_o !== CW'(8)) begin errors++; $display("FAIL reset_count: got %0d want 8", credit_count_o); end
        checks++; if (credits_full_o !== 1'b1) begin errors++; $display("FAIL reset_full: got %b want 1", credits_full_o); end
        checks++; if (credits_empty_o !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b want 0", credits_empty_o); end
        checks++; if (credit_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", credit_err_o); end
        model_reset();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL reset_idle_v: got %b want 0", mem_cmd_v_o); end
    endtask

    task automatic test_ordered_flow();
        step(1'b1, 64'h11, 1'b0, 1'b0);
        checks++; if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== 64'h11) begin errors++; $display("FAIL flow_head_a: got v=%b d=%h want v=1 d=11", mem_cmd_v_o, mem_cmd_o); end
        checks++; if (credit_count_o !== CW'(8)) begin errors++; $display("FAIL flow_count8: got %0d want 8", credit_count_o); end
        step(1'b1, 64'h22, 1'b1, 1'b0);
        checks++; if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== 64'h22) begin errors++; $display("FAIL flow_head_b: got v=%b d=%h want v=1 d=22", mem_cmd_v_o, mem_cmd_o); end
        checks++; if (credit_count_o !== CW'(7)) begin errors++; $display("FAIL flow_count7: got %0d want 7", credit_count_o); end
        checks++; if (mem_cmd_ready_o !== 1'b1) begin errors++; $display("FAIL flow_ready_occ1: got %b want 1", mem_cmd_ready_o); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (credit_count_o !== CW'(6) || mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL flow_count6: got cnt=%0d v=%b want cnt=6 v=0", credit_count_o, mem_cmd_v_o); end
        // Fill to two entries: ready must drop only while both are held.
        step(1'b1, 64'h33, 1'b0, 1'b0);
        step(1'b1, 64'h44, 1'b0, 1'b0);
        checks++; if (mem_cmd_ready_o !== 1'b0) begin errors++; $display("FAIL flow_ready_full: got %b want 0", mem_cmd_ready_o); end
        checks++; if (mem_cmd_o !== 64'h33) begin errors++; $display("FAIL flow_head_c: got %h want 33", mem_cmd_o); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (mem_cmd_ready_o !== 1'b1 || mem_cmd_o !== 64'h44) begin errors++; $display("FAIL flow_after_full: got rdy=%b d=%h want rdy=1 d=44", mem_cmd_ready_o, mem_cmd_o); end
        step(1'b0, '0, 1'b1, 1'b0);
        restore_credits();
        checks++; if (credits_full_o !== 1'b1) begin errors++; $display("FAIL flow_restore_full: got %b want 1", credits_full_o); end
    endtask

    task automatic test_credit_exhaustion();
        for (int i = 0; i < CRED; i++) begin
            step(1'b1, W'(64'h100 + i), 1'b0, 1'b0);
            checks++; if (mem_cmd_o !== W'(64'h100 + i) || mem_cmd_v_o !== 1'b1) begin errors++; $display("FAIL exh_issue_%0d: got v=%b d=%h want v=1 d=%h", i, mem_cmd_v_o, mem_cmd_o, 64'h100 + i); end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (credit_count_o !== CW'(0) || credits_empty_o !== 1'b1 || credits_full_o !== 1'b0) begin errors++; $display("FAIL exh_empty: got cnt=%0d e=%b f=%b want cnt=0 e=1 f=0", credit_count_o, credits_empty_o, credits_full_o); end
        step(1'b1, 64'h99, 1'b0, 1'b0);
        checks++; if (mem_cmd_v_o !== 1'b0 || mem_cmd_o !== 64'h99) begin errors++; $display("FAIL exh_stall: got v=%b d=%h want v=0 d=99", mem_cmd_v_o, mem_cmd_o); end
        // Illegal yumi while stalled must change nothing.
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (mem_cmd_v_o !== 1'b0 || mem_cmd_o !== 64'h99 || credit_count_o !== CW'(0)) begin errors++; $display("FAIL exh_bad_yumi: got v=%b d=%h cnt=%0d want v=0 d=99 cnt=0", mem_cmd_v_o, mem_cmd_o, credit_count_o); end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++; if (mem_cmd_v_o !== 1'b1 || credit_count_o !== CW'(1) || mem_cmd_o !== 64'h99) begin errors++; $display("FAIL exh_return: got v=%b cnt=%0d d=%h want v=1 cnt=1 d=99", mem_cmd_v_o, credit_count_o, mem_cmd_o); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (credit_count_o !== CW'(0) || mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL exh_reissue: got cnt=%0d v=%b want cnt=0 v=0", credit_count_o, mem_cmd_v_o); end
        restore_credits();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, W'(i + 1), 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        step(1'b1, 64'h55, 1'b0, 1'b0);
        checks++; if (credit_count_o !== CW'(5)) begin errors++; $display("FAIL sim_pre_count: got %0d want 5", credit_count_o); end
        step(1'b1, 64'h66, 1'b1, 1'b1);
        checks++; if (credit_count_o !== CW'(5)) begin errors++; $display("FAIL sim_count: got %0d want 5", credit_count_o); end
        checks++; if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== 64'h66 || mem_cmd_ready_o !== 1'b1) begin errors++; $display("FAIL sim_occ1: got v=%b d=%h rdy=%b want v=1 d=66 rdy=1", mem_cmd_v_o, mem_cmd_o, mem_cmd_ready_o); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (mem_cmd_v_o !== 1'b0 || credit_count_o !== CW'(4)) begin errors++; $display("FAIL sim_drain: got v=%b cnt=%0d want v=0 cnt=4", mem_cmd_v_o, credit_count_o); end
        restore_credits();
    endtask

    task automatic test_wrap_around();
        logic [W-1:0] got[$];
        int nxt = 1;
        int cycles = 0;
        while (got.size() < 7 && cycles < 500) begin
            logic v, y, r;
            v = (nxt <= 7) && ($urandom_range(0, 3) != 0);
            y = exp_v() && ($urandom_range(0, 2) != 0);
            r = (m_credits < CRED) && ($urandom_range(0, 1) == 1);
            if (y) got.push_back(mem_cmd_o);
            if (v && q.size() < ELS) nxt++;
            step(v, W'(nxt - ((v && q.size() < ELS) ? 1 : 0)), y, r);
            cycles++;
        end
        checks++; if (got.size() != 7) begin errors++; $display("FAIL wrap_count: got %0d want 7", got.size()); end
        for (int i = 0; i < got.size() && i < 7; i++) begin
            checks++; if (got[i] !== W'(i + 1)) begin errors++; $display("FAIL wrap_order_%0d: got %h want %h", i, got[i], i + 1); end
        end
        while (q.size() > 0 && cycles < 600) begin
            step(1'b0, '0, exp_v(), 1'b1);
            cycles++;
        end
        restore_credits();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic v, y, r;
            logic [W-1:0] d;
            d = {$urandom, $urandom};
            v = ($urandom_range(0, 1) == 1);
            y = exp_v() && ($urandom_range(0, 3) != 0);
            r = (m_credits < CRED) && ($urandom_range(0, 2) == 0);
            step(v, d, y, r);
            checks++; if (mem_cmd_ready_o !== (q.size() < ELS)) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", c, mem_cmd_ready_o, q.size() < ELS); end
            checks++; if (mem_cmd_v_o !== exp_v()) begin errors++; $display("FAIL rnd_v@%0d: got %b want %b", c, mem_cmd_v_o, exp_v()); end
            if (q.size() > 0) begin
                checks++; if (mem_cmd_o !== q[0]) begin errors++; $display("FAIL rnd_head@%0d: got %h want %h", c, mem_cmd_o, q[0]); end
            end
            checks++; if (credit_count_o !== CW'(m_credits)) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, credit_count_o, m_credits); end
            checks++; if (credits_empty_o !== (m_credits == 0) || credits_full_o !== (m_credits == CRED)) begin errors++; $display("FAIL rnd_flags@%0d: got e=%b f=%b want e=%b f=%b", c, credits_empty_o, credits_full_o, m_credits == 0, m_credits == CRED); end
            checks++; if (credit_err_o !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", c, credit_err_o, m_err); end
        end
        while (q.size() > 0) step(1'b0, '0, exp_v(), 1'b1);
        restore_credits();
    endtask

    task automatic test_overflow_and_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        checks++; if (credit_count_o !== CW'(8) || credit_err_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got cnt=%0d err=%b want cnt=8 err=1", credit_count_o, credit_err_o); end
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (credit_err_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", credit_err_o); end
        step(1'b1, 64'hA1, 1'b0, 1'b0);
        step(1'b1, 64'hA2, 1'b0, 1'b0);
        checks++; if (mem_cmd_ready_o !== 1'b0) begin errors++; $display("FAIL ovf_two_buffered: got rdy=%b want 0", mem_cmd_ready_o); end
        #2 reset_n_i = 1'b0;
        #1;
        checks++; if (credit_err_o !== 1'b0 || mem_cmd_v_o !== 1'b0 || mem_cmd_ready_o !== 1'b1 || credit_count_o !== CW'(8)) begin errors++; $display("FAIL mid_reset: got err=%b v=%b rdy=%b cnt=%0d want err=0 v=0 rdy=1 cnt=8", credit_err_o, mem_cmd_v_o, mem_cmd_ready_o, credit_count_o); end
        model_reset();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            checks++; if (mem_cmd_v_o !== 1'b0 || mem_cmd_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_idle_%0d: got v=%b rdy=%b want v=0 rdy=1", i, mem_cmd_v_o, mem_cmd_ready_o); end
        end
        step(1'b1, 64'hB7, 1'b0, 1'b0);
        checks++; if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== 64'hB7) begin errors++; $display("FAIL post_reset_head: got v=%b d=%h want v=1 d=b7", mem_cmd_v_o, mem_cmd_o); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++; if (mem_cmd_v_o !== 1'b0 || credit_count_o !== CW'(7)) begin errors++; $display("FAIL post_reset_drain: got v=%b cnt=%0d want v=0 cnt=7", mem_cmd_v_o, credit_count_o); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ordered_flow();
        test_credit_exhaustion();
        test_simultaneous();
        test_wrap_around();
        test_random();
        test_overflow_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_cce_mem_cmd_credit_buffer.md
Name: bp_cce_mem_cmd_credit_buffer

Overview:
- Outbound buffer between the CCE message unit's memory-command port and the memory network.
- Accepts ready&valid mem_cmd messages from the message unit into an els_p-entry FIFO, then issues them to memory using a valid->yumi handshake.
- Limits outstanding memory commands with a credit counter; a credit returns whenever the CCE consumes a mem_resp.
- Prevents the memory side from exceeding its response buffering capacity.

Parameters:
- msg_width_p, 64, width in bits of one packed CCE-memory message.
- els_p, 2, FIFO depth in entries; legal values are 2 or more.
- credits_p, 8, maximum outstanding memory commands; legal values are 1 or more.
- Derived: ptr_w = clog2(els_p), cnt_w = clog2(credits_p+1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  reset; asynchronous, active-low.
- mem_cmd_i  in  msg_width_p  command from the message unit.
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_ready_o  out  1  buffer can accept; transfer when v_i & ready_o.
- mem_cmd_o  out  msg_width_p  head-of-FIFO command to memory.
- mem_cmd_v_o  out  1  head valid and a credit is available.
- mem_cmd_yumi_i  in  1  memory consumes the head; legal only when mem_cmd_v_o=1.
- mem_resp_yumi_i  in  1  CCE consumed one mem_resp; returns one credit.
- credit_count_o  out  cnt_w  credits currently available.
- credits_empty_o  out  1  credit_count_o==0.
- credits_full_o  out  1  credit_count_o==credits_p (nothing outstanding).
- credit_err_o  out  1  sticky flag: a credit was returned while already full.

Behaviour:
- Reset (reset_n_i low, asynchronous, effective immediately):
  - FIFO read/write pointers = 0; FIFO empty.
  - credit_count_o = credits_p; credits_full_o = 1; credits_empty_o = 0.
  - credit_err_o = 0; mem_cmd_v_o = 0; mem_cmd_ready_o = 1.
  - FIFO storage contents are don't-care.
  - Reset mid-operation discards all buffered commands and restores all credits.
- Enqueue:
  - mem_cmd_ready_o = ~full, registered state only; it does not depend on mem_cmd_yumi_i in the same cycle.
  - On v_i & ready_o, write mem_cmd_i at wptr; wptr advances and wraps from els_p-1 to 0.
- Dequeue:
  - mem_cmd_o = entry at rptr, combinational from storage.
  - mem_cmd_v_o = ~empty & (credit_count_o != 0).
  - On mem_cmd_yumi_i, rptr advances with wrap.
- Latency: minimum 1 cycle from enqueue to mem_cmd_v_o; no bypass path.
- Full/empty: tracked with an occupancy counter of width clog2(els_p+1).
  - Counter increments on enqueue only, decrements on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue.
  - Simultaneous enqueue and dequeue is legal whenever the FIFO is not full, and also when occupancy is 1.
- Credits:
  - Decrement on mem_cmd_yumi_i; increment on mem_resp_yumi_i.
  - Both in the same cycle leave the count unchanged.
- Credit overflow:
  - Increment alone while count==credits_p saturates the count at credits_p and sets credit_err_o.
  - credit_err_o clears only on reset.
- Credit underflow cannot occur because mem_cmd_v_o is gated by credits.
  - mem_cmd_yumi_i while mem_cmd_v_o=0 is a protocol error: the block ignores it (no pointer or credit change).
- Ordering: strict FIFO; messages pass through unmodified.
- Data integrity: the head entry is stable while mem_cmd_v_o=1 or while stalled on credits.

Test Plan:
- Reset then idle:
  - Assert reset_n_i=0 asynchronously mid-cycle.
  - Require outputs immediately: ready_o=1, v_o=0, credit_count_o=8, credits_full_o=1, credit_err_o=0.
- Ordered flow (els_p=2):
  - Enqueue A=0x11, B=0x22 on back-to-back cycles, with yumi held 1 once v_o rises.
  - Require mem_cmd_o=0x11 then 0x22 in consecutive cycles; credit_count_o goes 8→7→6.
  - Require ready_o=0 for exactly the cycle when occupancy=2.
- Credit exhaustion (credits_p=8):
  - Issue 8 commands with no mem_resp_yumi_i.
  - Require credit_count_o=0, credits_empty_o=1.
  - Enqueue a 9th command: v_o=0, head held stable.
  - Pulse mem_resp_yumi_i once: v_o=1 next cycle, count=1→0 after the yumi.
- Simultaneous events:
  - Same cycle with count=5: mem_cmd_yumi_i=1 and mem_resp_yumi_i=1 → count stays 5.
  - Same cycle with occupancy=1: enqueue and dequeue → occupancy stays 1.
- Wrap-around:
  - Stream 7 commands (0x01..0x07) through els_p=2 with random yumi stalls.
  - Require output order 0x01..0x07 exactly, with no drop or duplicate.
- Overflow error and reset mid-operation:
  - Pulse mem_resp_yumi_i with count=8 → count stays 8, credit_err_o=1 and remains 1.
  - Assert reset with 2 commands buffered → err=0, empty, count=8; no stale command appears after reset release.
